time_set_entry: RTL and testbench
=================================

Name: time_set_entry

Overview:
- Keypad-driven time-setting front end. It produces the key_hour, key_minute and set_time inputs that the timekeeper consumes.
- The operator enters four digits in order: hour tens, hour units, minute tens, minute units. Each digit may be "kept" from the current time.
- The block range-checks the entry and issues a one-cycle commit strobe.
- All illegal-time filtering happens here, so the timekeeper always receives legal values.

Parameters:
- TIMEOUT_CYC, 100000000 — idle cycles between keys before entry aborts (about 1 s at the board clock).
- TO_W, 27 — timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- set_mode  in  1  one-cycle pulse (debounced upstream) requesting entry mode
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  4  0..9 digit; 0xA keep; 0xB confirm; 0xC cancel; 0xD..0xF ignored
- cur_hour  in  6  running hour 0..23 from timekeeper
- cur_minute  in  6  running minute 0..59 from timekeeper
- key_hour  out  6  committed hour, binary 0..23
- key_minute  out  6  committed minute, binary 0..59
- set_time  out  1  one-cycle commit strobe
- entry_active  out  1  high in any state except IDLE
- digit_pos  out  2  0 = hour tens, 1 = hour units, 2 = minute tens, 3 = minute units (valid while entry_active)
- key_err  out  1  one-cycle pulse on a rejected key

Behaviour:
- Reset (rst = 0, asynchronous):
  - state goes to IDLE.
  - key_hour, key_minute, set_time, entry_active, digit_pos, key_err and the timer all clear to 0.
- States: IDLE, HT, HU, MT, MU, CONF.
- IDLE:
  - set_mode moves to HT.
  - In the same edge, cur_hour and cur_minute are snapshotted into four BCD digit registers (sh1, sh0, sm1, sm0).
  - key_valid is ignored in IDLE.
- Entry states (HT/HU/MT/MU):
  - A digit or keep key writes the current position, then advances HT -> HU -> MT -> MU -> CONF.
  - Keep reuses the snapshot digit.
- Validation, using the effective digits (entered or kept):
  - HT: value must be 0..2.
  - HU: hour = 10*HT + HU must be <= 23.
  - MT: value must be 0..5.
  - MU: value must be 0..9.
  - Failing key: key_err pulses the next cycle, state and digits are unchanged.
  - Example: HT = 2 with a snapshot HU of 7, then keep at HU, gives 27. This is rejected and the operator must type a digit.
- Confirm (0xB):
  - Only legal in CONF; in HT..MU it is treated as a rejected key.
  - In CONF, on the next edge: key_hour = 10*h1 + h0 and key_minute = 10*m1 + m0 (6-bit binary).
  - set_time is high for exactly one cycle, and the state returns to IDLE.
  - key_hour and key_minute hold until the next commit.
- Other keys in CONF: digit and keep keys are rejected with key_err.
- Cancel (0xC), in any non-IDLE state: go to IDLE, no set_time, outputs unchanged.
- Keys 0xD..0xF: ignored, no error.
- Timeout:
  - The timer clears on entry to HT and on every accepted or rejected key_valid.
  - It increments each cycle while entry_active.
  - Reaching TIMEOUT_CYC-1 aborts to IDLE as for cancel.
  - If key_valid and expiry coincide, the key wins.
- set_mode while entry_active: ignored; no restart and no re-snapshot.
- set_mode and key_valid together in IDLE: enter HT, drop the key.
- digit_pos: tracks state (HT = 0 .. MU = 3). It holds 3 in CONF and 0 in IDLE.
- Binary-to-BCD of the snapshot: divide by 10 via compare/subtract; inputs are in range, so no error path.
- Latency: key_valid -> state change or key_err is 1 cycle; confirm -> set_time is 1 cycle.

Decomposition:
- Shared package time_pkg holds:
  - KEY_KEEP = 4'hA, KEY_OK = 4'hB, KEY_CANCEL = 4'hC.
  - MAX_HOUR = 23, MAX_MIN = 59.
  - State encoding constants for the entry FSM.
- One natural sub-module: entry_timer. It is a loadable TO_W-bit counter with clear, enable and expire outputs, parameterised by TIMEOUT_CYC, and is reusable for the alarm-set path.
- BCD split/join is combinational logic inside the top module.

Test Plan:
- Basic commit: rst, then set_mode; keys 1, 5, 3, 0, then OK. Expect set_time for 1 cycle with key_hour = 15 and key_minute = 30; entry_active falls the same edge.
- Keep path: cur = 09:47; set_mode; keys KEEP, KEEP, 2, KEEP, OK. Expect key_hour = 9, key_minute = 27.
- Range reject: set_mode; key 3 gives key_err with digit_pos still 0. Then 2, then 4 gives key_err at pos 1. Then 3, 5, 9, OK gives 23:59. Also cur = 17:00 with keys 2, KEEP gives key_err (27).
- Early confirm and cancel: OK at pos 1 gives key_err, no set_time. CANCEL at pos 2 gives IDLE, no set_time, key_hour/key_minute keep their previous values.
- Timeout: TIMEOUT_CYC = 8. After one digit, idle 8 cycles; expect entry_active = 0 and no set_time. Also a key arriving on the expiry cycle is accepted and the timer restarts.
- Async reset mid-entry: pull rst low at pos 2. Expect all outputs 0 immediately (before the next clk); after release, a key_valid alone does nothing until set_mode.

Source files
------------

// File: rtl/time_pkg.sv
// Shared constants, state encoding and BCD helpers for the time-setting entry path.
package time_pkg;

  localparam logic [3:0] KEY_KEEP   = 4'hA;
  localparam logic [3:0] KEY_OK     = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  localparam int unsigned MAX_HOUR = 23;
  localparam int unsigned MAX_MIN  = 59;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HT   = 3'd1,
    ST_HU   = 3'd2,
    ST_MT   = 3'd3,
    ST_MU   = 3'd4,
    ST_CONF = 3'd5
  } entry_state_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Divide by 10 via compare/subtract; valid for inputs below 80.
  function automatic bcd2_t bin_to_bcd(input logic [5:0] v);
    bcd2_t      b;
    logic [5:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    if (r >= 6'd40) begin r = r - 6'd40; t = t + 4'd4; end
    if (r >= 6'd20) begin r = r - 6'd20; t = t + 4'd2; end
    if (r >= 6'd10) begin r = r - 6'd10; t = t + 4'd1; end
    b.tens = t;
    b.ones = 4'(r);
    return b;
  endfunction

  function automatic logic [6:0] bcd_join(input logic [3:0] tens, input logic [3:0] ones);
    return (7'(tens) * 7'd10) + 7'(ones);
  endfunction

endpackage

// File: rtl/time_set_entry_if.sv
// Keypad/timekeeper signal bundle for the time-setting entry block.
interface time_set_entry_if;
  logic       set_mode;
  logic       key_valid;
  logic [3:0] key_code;
  logic [5:0] cur_hour;
  logic [5:0] cur_minute;
  logic [5:0] key_hour;
  logic [5:0] key_minute;
  logic       set_time;
  logic       entry_active;
  logic [1:0] digit_pos;
  logic       key_err;

  modport master (
    output set_mode, key_valid, key_code, cur_hour, cur_minute,
    input  key_hour, key_minute, set_time, entry_active, digit_pos, key_err
  );

  modport slave (
    input  set_mode, key_valid, key_code, cur_hour, cur_minute,
    output key_hour, key_minute, set_time, entry_active, digit_pos, key_err
  );
endinterface

// File: rtl/entry_timer.sv
// Loadable inactivity counter; expire_o is high while the count sits at TIMEOUT_CYC-1.
module entry_timer #(
  parameter int unsigned TIMEOUT_CYC = 100000000,
  parameter int unsigned TO_W        = 27
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            load_i,
  input  logic [TO_W-1:0] load_val_i,
  output logic            expire_o
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            expire_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (load_i) cnt_d = load_val_i;
    else if (en_i)   cnt_d = cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= (cnt_d == LAST);
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/time_set_entry.sv
// Keypad time-entry front end: four range-checked BCD digits, keep/confirm/cancel, idle timeout.
module time_set_entry
  import time_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100000000,
  parameter int unsigned TO_W        = 27
) (
  input  logic             clk,
  input  logic             rst,
  time_set_entry_if.slave  bus
);

  entry_state_e     state_q, state_d, adv_c;
  logic [3:0][3:0]  dig_q, dig_d;
  logic [1:0]       pos_c;
  logic [3:0]       eff_c;
  logic             is_digit_c, is_keep_c, is_ok_c, is_cancel_c, legal_c;
  logic             commit_c, err_c, tmr_clr_c, expire_c;
  bcd2_t            hour_bcd_c, min_bcd_c;

  logic [5:0] key_hour_q, key_hour_d, key_minute_q, key_minute_d;
  logic       set_time_q, set_time_d, entry_active_q, entry_active_d;
  logic       key_err_q, key_err_d;
  logic [1:0] digit_pos_q, digit_pos_d;

  entry_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (tmr_clr_c),
    .en_i       (state_q != ST_IDLE),
    .load_i     (1'b0),
    .load_val_i ('0),
    .expire_o   (expire_c)
  );

  // Key decode and validation against the effective (entered or kept) digit.
  always_comb begin
    hour_bcd_c  = bin_to_bcd(bus.cur_hour);
    min_bcd_c   = bin_to_bcd(bus.cur_minute);
    is_digit_c  = (bus.key_code <= 4'd9);
    is_keep_c   = (bus.key_code == KEY_KEEP);
    is_ok_c     = (bus.key_code == KEY_OK);
    is_cancel_c = (bus.key_code == KEY_CANCEL);
    pos_c       = 2'd0;
    adv_c       = ST_IDLE;
    unique case (state_q)
      ST_HT:   begin pos_c = 2'd0; adv_c = ST_HU;   end
      ST_HU:   begin pos_c = 2'd1; adv_c = ST_MT;   end
      ST_MT:   begin pos_c = 2'd2; adv_c = ST_MU;   end
      ST_MU:   begin pos_c = 2'd3; adv_c = ST_CONF; end
      default: begin pos_c = 2'd0; adv_c = ST_IDLE; end
    endcase
    eff_c   = is_keep_c ? dig_q[pos_c] : bus.key_code;
    legal_c = 1'b0;
    unique case (state_q)
      ST_HT:   legal_c = (eff_c <= 4'(MAX_HOUR / 10));
      ST_HU:   legal_c = (bcd_join(dig_q[0], eff_c) <= 7'(MAX_HOUR));
      ST_MT:   legal_c = (eff_c <= 4'(MAX_MIN / 10));
      ST_MU:   legal_c = (bcd_join(dig_q[2], eff_c) <= 7'(MAX_MIN));
      default: legal_c = 1'b0;
    endcase
  end

  // Next-state and digit-register update.
  always_comb begin
    state_d   = state_q;
    dig_d     = dig_q;
    commit_c  = 1'b0;
    err_c     = 1'b0;
    tmr_clr_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.set_mode) begin
          state_d   = ST_HT;
          tmr_clr_c = 1'b1;
          dig_d[0]  = hour_bcd_c.tens;
          dig_d[1]  = hour_bcd_c.ones;
          dig_d[2]  = min_bcd_c.tens;
          dig_d[3]  = min_bcd_c.ones;
        end
      end
      ST_HT, ST_HU, ST_MT, ST_MU: begin
        if (bus.key_valid) begin
          tmr_clr_c = 1'b1;
          if (is_cancel_c) begin
            state_d = ST_IDLE;
          end else if (is_digit_c || is_keep_c) begin
            if (legal_c) begin
              dig_d[pos_c] = eff_c;
              state_d      = adv_c;
            end else begin
              err_c = 1'b1;
            end
          end else if (is_ok_c) begin
            err_c = 1'b1;
          end
        end else if (expire_c) begin
          state_d = ST_IDLE;
        end
      end
      ST_CONF: begin
        if (bus.key_valid) begin
          tmr_clr_c = 1'b1;
          if (is_cancel_c) begin
            state_d = ST_IDLE;
          end else if (is_ok_c) begin
            commit_c = 1'b1;
            state_d  = ST_IDLE;
          end else if (is_digit_c || is_keep_c) begin
            err_c = 1'b1;
          end
        end else if (expire_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next values; all outputs leave through registers.
  always_comb begin
    key_hour_d     = key_hour_q;
    key_minute_d   = key_minute_q;
    if (commit_c) begin
      key_hour_d   = 6'(bcd_join(dig_q[0], dig_q[1]));
      key_minute_d = 6'(bcd_join(dig_q[2], dig_q[3]));
    end
    set_time_d     = commit_c;
    key_err_d      = err_c;
    entry_active_d = (state_d != ST_IDLE);
    unique case (state_d)
      ST_HU:            digit_pos_d = 2'd1;
      ST_MT:            digit_pos_d = 2'd2;
      ST_MU, ST_CONF:   digit_pos_d = 2'd3;
      default:          digit_pos_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      dig_q          <= '0;
      key_hour_q     <= 6'd0;
      key_minute_q   <= 6'd0;
      set_time_q     <= 1'b0;
      entry_active_q <= 1'b0;
      digit_pos_q    <= 2'd0;
      key_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      dig_q          <= dig_d;
      key_hour_q     <= key_hour_d;
      key_minute_q   <= key_minute_d;
      set_time_q     <= set_time_d;
      entry_active_q <= entry_active_d;
      digit_pos_q    <= digit_pos_d;
      key_err_q      <= key_err_d;
    end
  end

  assign bus.key_hour     = key_hour_q;
  assign bus.key_minute   = key_minute_q;
  assign bus.set_time     = set_time_q;
  assign bus.entry_active = entry_active_q;
  assign bus.digit_pos    = digit_pos_q;
  assign bus.key_err      = key_err_q;

endmodule

// File: tb/tb_time_set_entry.sv
// Scoreboard bench for time_set_entry: expected commits are queued on confirm and popped on set_time.
module tb_time_set_entry;

  localparam logic [3:0] K_KEEP   = 4'hA;
  localparam logic [3:0] K_OK     = 4'hB;
  localparam logic [3:0] K_CANCEL = 4'hC;

  typedef struct {
    logic [5:0] h;
    logic [5:0] m;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  time_set_entry_if bus ();

  time_set_entry #(
    .TIMEOUT_CYC (8),
    .TO_W        (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] k);
    bus.key_code  = k;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic enter(input logic [5:0] h, input logic [5:0] m);
    bus.cur_hour   = h;
    bus.cur_minute = m;
    bus.set_mode   = 1'b1;
    @(negedge clk);
    bus.set_mode   = 1'b0;
  endtask

  task automatic confirm(input logic [5:0] h, input logic [5:0] m);
    exp_t e;
    e.h = h;
    e.m = m;
    sb_q.push_back(e);
    press(K_OK);
    check("set_time_on_ok", 32'(bus.set_time), 32'd1);
    check("active_after_ok", 32'(bus.entry_active), 32'd0);
  endtask

  // Commit monitor: every set_time must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && bus.set_time === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("set_time_unexpected", 32'(bus.set_time), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("key_hour", 32'(bus.key_hour), 32'(e.h));
        check("key_minute", 32'(bus.key_minute), 32'(e.m));
      end
    end
  end

  initial begin
    bus.set_mode   = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_code   = 4'h0;
    bus.cur_hour   = 6'd0;
    bus.cur_minute = 6'd0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst_key_hour", 32'(bus.key_hour), 32'd0);
    check("rst_key_minute", 32'(bus.key_minute), 32'd0);
    check("rst_set_time", 32'(bus.set_time), 32'd0);
    check("rst_active", 32'(bus.entry_active), 32'd0);
    check("rst_pos", 32'(bus.digit_pos), 32'd0);
    check("rst_err", 32'(bus.key_err), 32'd0);
    idle(2);
    rst = 1'b1;
    idle(1);

    // Keys in IDLE are ignored.
    press(4'd5);
    check("idle_key_active", 32'(bus.entry_active), 32'd0);
    check("idle_key_err", 32'(bus.key_err), 32'd0);

    // Basic commit 15:30, with a stray set_mode mid-entry.
    enter(6'd12, 6'd34);
    check("enter_active", 32'(bus.entry_active), 32'd1);
    check("enter_pos", 32'(bus.digit_pos), 32'd0);
    press(4'd1);
    check("basic_pos1", 32'(bus.digit_pos), 32'd1);
    enter(6'd20, 6'd20);
    check("set_mode_ignored_pos", 32'(bus.digit_pos), 32'd1);
    press(4'd5);
    check("basic_pos2", 32'(bus.digit_pos), 32'd2);
    press(4'd3);
    check("basic_pos3", 32'(bus.digit_pos), 32'd3);
    press(4'd0);
    check("basic_conf_pos", 32'(bus.digit_pos), 32'd3);
    check("basic_no_err", 32'(bus.key_err), 32'd0);
    confirm(6'd15, 6'd30);
    check("basic_pos_idle", 32'(bus.digit_pos), 32'd0);
    idle(1);
    check("set_time_one_cycle", 32'(bus.set_time), 32'd0);

    // Keep path from 09:47.
    enter(6'd9, 6'd47);
    press(K_KEEP);
    press(K_KEEP);
    press(4'd2);
    press(K_KEEP);
    check("keep_conf_pos", 32'(bus.digit_pos), 32'd3);
    confirm(6'd9, 6'd27);

    // Range rejects, then 23:59.
    enter(6'd0, 6'd0);
    press(4'd3);
    check("ht3_err", 32'(bus.key_err), 32'd1);
    check("ht3_pos", 32'(bus.digit_pos), 32'd0);
    press(4'd2);
    check("ht2_err", 32'(bus.key_err), 32'd0);
    check("ht2_pos", 32'(bus.digit_pos), 32'd1);
    press(4'd4);
    check("hu4_err", 32'(bus.key_err), 32'd1);
    check("hu4_pos", 32'(bus.digit_pos), 32'd1);
    press(4'd3);
    press(4'd6);
    check("mt6_err", 32'(bus.key_err), 32'd1);
    check("mt6_pos", 32'(bus.digit_pos), 32'd2);
    press(4'd5);
    press(4'd9);
    check("max_conf_pos", 32'(bus.digit_pos), 32'd3);
    confirm(6'd23, 6'd59);

    // Keep producing hour 27 is rejected.
    enter(6'd17, 6'd0);
    press(4'd2);
    press(K_KEEP);
    check("keep27_err", 32'(bus.key_err), 32'd1);
    check("keep27_pos", 32'(bus.digit_pos), 32'd1);
    press(4'hE);
    check("ignored_key_err", 32'(bus.key_err), 32'd0);
    check("ignored_key_pos", 32'(bus.digit_pos), 32'd1);

    // Early confirm rejected, then cancel keeps previous outputs.
    press(K_OK);
    check("early_ok_err", 32'(bus.key_err), 32'd1);
    check("early_ok_no_set", 32'(bus.set_time), 32'd0);
    press(4'd1);
    check("after_early_pos", 32'(bus.digit_pos), 32'd2);
    press(K_CANCEL);
    check("cancel_active", 32'(bus.entry_active), 32'd0);
    check("cancel_no_set", 32'(bus.set_time), 32'd0);
    check("cancel_hour_held", 32'(bus.key_hour), 32'd23);
    check("cancel_min_held", 32'(bus.key_minute), 32'd59);

    // Digit in CONF rejected; set_mode with key in IDLE drops the key.
    bus.key_code  = 4'd1;
    bus.key_valid = 1'b1;
    enter(6'd0, 6'd0);
    bus.key_valid = 1'b0;
    check("setmode_key_pos", 32'(bus.digit_pos), 32'd0);
    check("setmode_key_active", 32'(bus.entry_active), 32'd1);
    press(4'd0); press(4'd0); press(4'd0); press(4'd0);
    press(4'd5);
    check("conf_digit_err", 32'(bus.key_err), 32'd1);
    check("conf_digit_active", 32'(bus.entry_active), 32'd1);
    press(K_CANCEL);

    // Timeout after 8 idle cycles.
    enter(6'd0, 6'd0);
    press(4'd1);
    idle(7);
    check("to_before_active", 32'(bus.entry_active), 32'd1);
    idle(1);
    check("to_abort_active", 32'(bus.entry_active), 32'd0);
    check("to_abort_pos", 32'(bus.digit_pos), 32'd0);

    // Key on the expiry cycle wins and restarts the timer.
    enter(6'd0, 6'd0);
    press(4'd1);
    idle(7);
    press(4'd2);
    check("to_key_wins_active", 32'(bus.entry_active), 32'd1);
    check("to_key_wins_pos", 32'(bus.digit_pos), 32'd2);
    idle(7);
    check("to_restart_active", 32'(bus.entry_active), 32'd1);
    idle(1);
    check("to_restart_abort", 32'(bus.entry_active), 32'd0);

    // Asynchronous reset mid-entry.
    enter(6'd0, 6'd0);
    press(4'd1);
    press(4'd2);
    check("pre_rst_pos", 32'(bus.digit_pos), 32'd2);
    #2 rst = 1'b0;
    #1;
    check("arst_key_hour", 32'(bus.key_hour), 32'd0);
    check("arst_key_minute", 32'(bus.key_minute), 32'd0);
    check("arst_active", 32'(bus.entry_active), 32'd0);
    check("arst_pos", 32'(bus.digit_pos), 32'd0);
    check("arst_err", 32'(bus.key_err), 32'd0);
    check("arst_set_time", 32'(bus.set_time), 32'd0);
    idle(2);
    rst = 1'b1;
    idle(1);
    press(4'd1);
    check("post_rst_key_active", 32'(bus.entry_active), 32'd0);
    check("post_rst_key_pos", 32'(bus.digit_pos), 32'd0);
    enter(6'd0, 6'd0);
    press(4'd0); press(4'd8); press(4'd1); press(4'd5);
    confirm(6'd8, 6'd15);
    idle(2);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
